// File: rtl/demux_dispatch_ctrl_if.sv
// Bundle between the dispatch controller, its valid/ready source, the demux
// and the two channel consumers. The controller takes the slave side.
interface demux_dispatch_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] in_data;
    logic              in_dest;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] dmx_data;
    logic              dmx_sel;
    logic              ch0_stb;
    logic              ch1_stb;
    logic              ch0_ack;
    logic              ch1_ack;
    logic              timeout_err;
    logic [CNT_W-1:0]  sent_cnt0;
    logic [CNT_W-1:0]  sent_cnt1;
    logic [CNT_W-1:0]  drop_cnt;

    modport slave (
        input  in_data, in_dest, in_valid, ch0_ack, ch1_ack,
        output in_ready, dmx_data, dmx_sel, ch0_stb, ch1_stb,
               timeout_err, sent_cnt0, sent_cnt1, drop_cnt
    );

    modport master (
        output in_data, in_dest, in_valid, ch0_ack, ch1_ack,
        input  in_ready, dmx_data, dmx_sel, ch0_stb, ch1_stb,
               timeout_err, sent_cnt0, sent_cnt1, drop_cnt
    );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// Feeds the two-channel demux one word at a time: settle data/selector, strobe
// the chosen channel until ack or timeout, and keep delivery/drop statistics.
module demux_dispatch_ctrl #(
    parameter int DATA_W      = 32,
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_dispatch_ctrl_if.slave dd_if
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;

    localparam int              TO_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [3:0]      SETUP_LOAD = 4'(SETUP_CYC - 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit              TO_EN      = (TIMEOUT_CYC != 0);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              sel_q, sel_d;
    logic              stb0_q, stb0_d;
    logic              stb1_q, stb1_d;
    logic              terr_q, terr_d;
    logic [3:0]        setup_cnt_q, setup_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]  sent0_q, sent0_d;
    logic [CNT_W-1:0]  sent1_q, sent1_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              sel_ack;

    // Only the ack of the channel currently addressed can complete a transfer.
    assign sel_ack = sel_q ? dd_if.ch1_ack : dd_if.ch0_ack;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        data_d      = data_q;
        sel_d       = sel_q;
        stb0_d      = stb0_q;
        stb1_d      = stb1_q;
        terr_d      = 1'b0;
        setup_cnt_d = setup_cnt_q;
        to_cnt_d    = to_cnt_q;
        sent0_d     = sent0_q;
        sent1_d     = sent1_q;
        drop_d      = drop_q;

        case (state_q)
            ST_IDLE: begin
                if (dd_if.in_valid) begin
                    data_d      = dd_if.in_data;
                    sel_d       = dd_if.in_dest;
                    setup_cnt_d = SETUP_LOAD;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (setup_cnt_q != 4'd0) begin
                    setup_cnt_d = setup_cnt_q - 4'd1;
                end else begin
                    stb0_d   = ~sel_q;
                    stb1_d   = sel_q;
                    to_cnt_d = '0;
                    state_d  = ST_STROBE;
                end
            end
            ST_STROBE: begin
                // Ack is tested before the timeout so a coincident ack still delivers.
                if (sel_ack) begin
                    stb0_d  = 1'b0;
                    stb1_d  = 1'b0;
                    state_d = ST_IDLE;
                    if (sel_q) begin
                        if (sent1_q != '1) sent1_d = sent1_q + CNT_W'(1);
                    end else begin
                        if (sent0_q != '1) sent0_d = sent0_q + CNT_W'(1);
                    end
                end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
                    stb0_d  = 1'b0;
                    stb1_d  = 1'b0;
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                    if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: begin
                stb0_d  = 1'b0;
                stb1_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            sel_q       <= 1'b0;
            stb0_q      <= 1'b0;
            stb1_q      <= 1'b0;
            terr_q      <= 1'b0;
            setup_cnt_q <= '0;
            to_cnt_q    <= '0;
            sent0_q     <= '0;
            sent1_q     <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            stb0_q      <= stb0_d;
            stb1_q      <= stb1_d;
            terr_q      <= terr_d;
            setup_cnt_q <= setup_cnt_d;
            to_cnt_q    <= to_cnt_d;
            sent0_q     <= sent0_d;
            sent1_q     <= sent1_d;
            drop_q      <= drop_d;
        end
    end

    assign dd_if.in_ready    = (state_q == ST_IDLE);
    assign dd_if.dmx_data    = data_q;
    assign dd_if.dmx_sel     = sel_q;
    assign dd_if.ch0_stb     = stb0_q;
    assign dd_if.ch1_stb     = stb1_q;
    assign dd_if.timeout_err = terr_q;
    assign dd_if.sent_cnt0   = sent0_q;
    assign dd_if.sent_cnt1   = sent1_q;
    assign dd_if.drop_cnt    = drop_q;
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Two controllers (default timing, and a short-timeout/4-bit-counter variant)
// share one stimulus stream and are compared every cycle against a transaction model.
module tb_demux_dispatch_ctrl;
    localparam int A_SETUP = 2;
    localparam int A_TMO   = 64;
    localparam int A_CW    = 16;
    localparam int B_SETUP = 3;
    localparam int B_TMO   = 4;
    localparam int B_CW    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_dest = 1'b0;
    logic        ack0 = 1'b0;
    logic        ack1 = 1'b0;
    logic [31:0] in_data = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    demux_dispatch_ctrl_if #(.DATA_W(32), .CNT_W(A_CW)) if_a ();
    demux_dispatch_ctrl_if #(.DATA_W(32), .CNT_W(B_CW)) if_b ();

    assign if_a.in_data  = in_data;
    assign if_a.in_dest  = in_dest;
    assign if_a.in_valid = in_valid;
    assign if_a.ch0_ack  = ack0;
    assign if_a.ch1_ack  = ack1;
    assign if_b.in_data  = in_data;
    assign if_b.in_dest  = in_dest;
    assign if_b.in_valid = in_valid;
    assign if_b.ch0_ack  = ack0;
    assign if_b.ch1_ack  = ack1;

    demux_dispatch_ctrl #(.DATA_W(32), .SETUP_CYC(A_SETUP), .TIMEOUT_CYC(A_TMO), .CNT_W(A_CW))
        u_dut_a (.clk(clk), .rst_n(rst_n), .dd_if(if_a.slave));
    demux_dispatch_ctrl #(.DATA_W(32), .SETUP_CYC(B_SETUP), .TIMEOUT_CYC(B_TMO), .CNT_W(B_CW))
        u_dut_b (.clk(clk), .rst_n(rst_n), .dd_if(if_b.slave));

    // Transaction-level view: a word in flight and how many edges since it was taken.
    typedef struct packed {
        bit          busy;
        int          age;
        logic [31:0] data;
        bit          sel;
        bit          terr;
        int          sent0;
        int          sent1;
        int          drop;
    } mdl_t;

    mdl_t ma, mb;
    bit   model_ok = 1'b0;

    function automatic int sat_inc(int v, int cmax);
        return (v < cmax) ? v + 1 : v;
    endfunction

    function automatic mdl_t step(mdl_t m, int setup, int tmo, int cmax, bit rst, bit valid,
                                  logic [31:0] d, bit dest, bit a0, bit a1);
        mdl_t r = m;
        int   held;
        if (!rst) begin
            r.busy = 0; r.age = 0; r.data = '0; r.sel = 0; r.terr = 0;
            r.sent0 = 0; r.sent1 = 0; r.drop = 0;
            return r;
        end
        r.terr = 0;
        if (!m.busy) begin
            if (valid) begin
                r.busy = 1; r.age = 0; r.data = d; r.sel = dest;
            end
        end else begin
            r.age = m.age + 1;
            if (r.age > setup) begin
                held = r.age - setup;
                if (m.sel ? a1 : a0) begin
                    r.busy = 0;
                    if (m.sel) r.sent1 = sat_inc(m.sent1, cmax);
                    else       r.sent0 = sat_inc(m.sent0, cmax);
                end else if (tmo != 0 && held == tmo) begin
                    r.busy = 0;
                    r.terr = 1;
                    r.drop = sat_inc(m.drop, cmax);
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        ma  <= step(ma, A_SETUP, A_TMO, (1 << A_CW) - 1, rst_n, in_valid, in_data, in_dest, ack0, ack1);
        mb  <= step(mb, B_SETUP, B_TMO, (1 << B_CW) - 1, rst_n, in_valid, in_data, in_dest, ack0, ack1);
        cyc <= cyc + 1;
        if (!rst_n) model_ok <= 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            check("a.in_ready",    64'(if_a.in_ready),    64'(!ma.busy));
            check("a.dmx_data",    64'(if_a.dmx_data),    64'(ma.data));
            check("a.dmx_sel",     64'(if_a.dmx_sel),     64'(ma.sel));
            check("a.ch0_stb",     64'(if_a.ch0_stb),     64'(ma.busy && ma.age >= A_SETUP && !ma.sel));
            check("a.ch1_stb",     64'(if_a.ch1_stb),     64'(ma.busy && ma.age >= A_SETUP && ma.sel));
            check("a.timeout_err", 64'(if_a.timeout_err), 64'(ma.terr));
            check("a.sent_cnt0",   64'(if_a.sent_cnt0),   64'(ma.sent0));
            check("a.sent_cnt1",   64'(if_a.sent_cnt1),   64'(ma.sent1));
            check("a.drop_cnt",    64'(if_a.drop_cnt),    64'(ma.drop));
            check("b.in_ready",    64'(if_b.in_ready),    64'(!mb.busy));
            check("b.dmx_data",    64'(if_b.dmx_data),    64'(mb.data));
            check("b.dmx_sel",     64'(if_b.dmx_sel),     64'(mb.sel));
            check("b.ch0_stb",     64'(if_b.ch0_stb),     64'(mb.busy && mb.age >= B_SETUP && !mb.sel));
            check("b.ch1_stb",     64'(if_b.ch1_stb),     64'(mb.busy && mb.age >= B_SETUP && mb.sel));
            check("b.timeout_err", 64'(if_b.timeout_err), 64'(mb.terr));
            check("b.sent_cnt0",   64'(if_b.sent_cnt0),   64'(mb.sent0));
            check("b.sent_cnt1",   64'(if_b.sent_cnt1),   64'(mb.sent1));
            check("b.drop_cnt",    64'(if_b.drop_cnt),    64'(mb.drop));
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_wait();
        int n = 0;
        while (!(if_a.in_ready && if_b.in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait_bound", 64'(n < 200), 64'd1);
    endtask

    // Waits (bounded) until the given strobe is observed high.
    task automatic wait_stb(input bit dut_b, input bit ch);
        int n = 0;
        while (!(dut_b ? (ch ? if_b.ch1_stb : if_b.ch0_stb)
                       : (ch ? if_a.ch1_stb : if_a.ch0_stb)) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_stb_bound", 64'(n < 40), 64'd1);
    endtask

    initial begin
        int hi;
        int guard;
        int acc[$];

        apply_reset();
        check("rst.a.in_ready", 64'(if_a.in_ready), 64'd1);
        check("rst.a.sent_cnt0", 64'(if_a.sent_cnt0), 64'd0);

        // Word to channel 0 with ack on the first strobe cycle.
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_dest = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("t1.dmx_data", 64'(if_a.dmx_data), 64'hDEADBEEF);
        check("t1.dmx_sel", 64'(if_a.dmx_sel), 64'd0);
        check("t1.stb_e0", 64'(if_a.ch0_stb), 64'd0);
        @(negedge clk);
        check("t1.stb_e1", 64'(if_a.ch0_stb), 64'd0);
        @(negedge clk);
        check("t1.stb_e2", 64'(if_a.ch0_stb), 64'd1);
        check("t1.ch1_stb", 64'(if_a.ch1_stb), 64'd0);
        ack0 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
        check("t1.stb_e3", 64'(if_a.ch0_stb), 64'd0);
        check("t1.sent_cnt0", 64'(if_a.sent_cnt0), 64'd1);
        check("t1.in_ready", 64'(if_a.in_ready), 64'd1);

        // Channel 1 with the wrong-channel ack held high and a late correct ack.
        idle_wait();
        in_valid = 1'b1; in_data = 32'h12345678; in_dest = 1'b1; ack0 = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_stb(1'b0, 1'b1);
        hi = 0;
        while (if_a.ch1_stb && hi < 20) begin
            hi++;
            if (hi == 5) ack1 = 1'b1;
            @(negedge clk);
        end
        ack0 = 1'b0; ack1 = 1'b0;
        check("t2.stb_cycles", 64'(hi), 64'd5);
        check("t2.sent_cnt1", 64'(if_a.sent_cnt1), 64'd1);
        check("t2.sent_cnt0", 64'(if_a.sent_cnt0), 64'd1);

        // Short-timeout controller: no ack, word is dropped.
        apply_reset();
        in_valid = 1'b1; in_data = $urandom; in_dest = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_stb(1'b1, 1'b0);
        hi = 0;
        while (if_b.ch0_stb && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        check("t3.stb_cycles", 64'(hi), 64'd4);
        check("t3.timeout_err", 64'(if_b.timeout_err), 64'd1);
        check("t3.drop_cnt", 64'(if_b.drop_cnt), 64'd1);
        check("t3.in_ready", 64'(if_b.in_ready), 64'd1);
        @(negedge clk);
        check("t3.err_pulse", 64'(if_b.timeout_err), 64'd0);

        // Ack on the same edge the timeout would fire: ack wins.
        apply_reset();
        in_valid = 1'b1; in_data = $urandom; in_dest = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_stb(1'b1, 1'b0);
        hi = 0;
        while (if_b.ch0_stb && hi < 20) begin
            hi++;
            if (hi == 4) ack0 = 1'b1;
            @(negedge clk);
        end
        ack0 = 1'b0;
        check("t4.stb_cycles", 64'(hi), 64'd4);
        check("t4.timeout_err", 64'(if_b.timeout_err), 64'd0);
        check("t4.sent_cnt0", 64'(if_b.sent_cnt0), 64'd1);
        check("t4.drop_cnt", 64'(if_b.drop_cnt), 64'd0);

        // Reset in the middle of a channel-1 strobe.
        apply_reset();
        in_valid = 1'b1; in_data = 32'h0BADF00D; in_dest = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_stb(1'b0, 1'b1);
        ack1 = 1'b1;
        @(negedge clk);
        ack1 = 1'b0;
        check("t5.pre_sent_cnt1", 64'(if_a.sent_cnt1), 64'd1);
        in_valid = 1'b1; in_data = 32'h77778888; in_dest = 1'b1;
        guard = 0;
        while (!if_a.in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_stb(1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5.ch1_stb", 64'(if_a.ch1_stb), 64'd0);
        check("t5.dmx_sel", 64'(if_a.dmx_sel), 64'd0);
        check("t5.dmx_data", 64'(if_a.dmx_data), 64'd0);
        check("t5.sent_cnt1", 64'(if_a.sent_cnt1), 64'd0);
        check("t5.in_ready", 64'(if_a.in_ready), 64'd1);
        in_valid = 1'b1; in_data = 32'hA5A50F0F; in_dest = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_stb(1'b0, 1'b0);
        ack0 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
        check("t5.post_sent_cnt0", 64'(if_a.sent_cnt0), 64'd1);
        check("t5.post_data", 64'(if_a.dmx_data), 64'hA5A50F0F);

        // 17 back-to-back words into the 4-bit-counter controller.
        apply_reset();
        ack0 = 1'b1; in_dest = 1'b0; in_data = $urandom; in_valid = 1'b1;
        guard = 0;
        while (acc.size() < 17 && guard < 2000) begin
            if (if_b.in_ready) acc.push_back(cyc);
            @(negedge clk);
            in_data = $urandom;
            guard++;
        end
        in_valid = 1'b0;
        check("t6.accept_bound", 64'(guard < 2000), 64'd1);
        for (int i = 1; i < acc.size(); i++)
            check("t6.spacing", 64'(acc[i] - acc[i-1]), 64'(B_SETUP + 2));
        idle_wait();
        ack0 = 1'b0;
        check("t6.sent_cnt0_sat", 64'(if_b.sent_cnt0), 64'd15);

        // Random traffic with occasional resets, checked by the model only.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(3) != 0);
            in_dest  = 1'($urandom);
            in_data  = $urandom;
            ack0     = ($urandom_range(2) == 0);
            ack1     = ($urandom_range(2) == 0);
            rst_n    = ($urandom_range(399) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; ack0 = 1'b0; ack1 = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/demux_dispatch_ctrl.md
Name: demux_dispatch_ctrl

Overview:
- Upstream stage for the 32-bit two-channel demux; drives its data input and selector.
- Accepts words from a valid/ready source, each tagged with a destination bit.
- Holds the word and selector stable for a settle period, then raises a strobe on the selected channel until that channel's consumer acks.
- Keeps per-channel delivery counters and a timeout/drop counter, so consumers of the tri-stated demux outputs know exactly when their channel carries valid data.

Parameters:
- DATA_W, 32, width of the data word; matches the demux data path.
- SETUP_CYC, 2, cycles between driving dmx_data/dmx_sel and raising the strobe; legal range is 1..15.
- TIMEOUT_CYC, 64, strobe-high cycles without ack before the word is dropped; 0 disables the timeout.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  DATA_W  source word.
- in_dest  in  1  destination: 0 selects channel 0, 1 selects channel 1.
- in_valid  in  1  source word valid.
- in_ready  out  1  block can accept a word.
- dmx_data  out  DATA_W  to demux data input.
- dmx_sel  out  1  to demux selector.
- ch0_stb  out  1  channel 0 data valid.
- ch1_stb  out  1  channel 1 data valid.
- ch0_ack  in  1  channel 0 consumer took the word.
- ch1_ack  in  1  channel 1 consumer took the word.
- timeout_err  out  1  one-cycle pulse when a word is dropped.
- sent_cnt0  out  CNT_W  words delivered on channel 0, saturating.
- sent_cnt1  out  CNT_W  words delivered on channel 1, saturating.
- drop_cnt  out  CNT_W  words dropped by timeout, saturating.

Behaviour:
- Reset, sampled on a rising edge with rst_n=0, overrides everything and aborts any transfer in flight:
  - state goes to IDLE;
  - dmx_data=0, dmx_sel=0;
  - ch0_stb=0, ch1_stb=0, timeout_err=0;
  - all counters are cleared;
  - in_ready=1 in the first cycle after reset.
- Output timing:
  - in_ready is combinational and equals (state==IDLE).
  - All other outputs are registered.
- FSM states are IDLE, SETUP and STROBE.
- IDLE:
  - dmx_data/dmx_sel hold their last values.
  - On an edge with in_valid & in_ready, register in_data into dmx_data and in_dest into dmx_sel, load the setup counter with SETUP_CYC-1, and go to SETUP.
- SETUP:
  - Both strobes stay low.
  - While the counter is nonzero, decrement it.
  - At zero, raise ch[dmx_sel]_stb, clear the timeout counter, and go to STROBE.
  - Net timing: handshake at edge E0 puts the strobe high from edge E0+SETUP_CYC.
- STROBE:
  - Only the selected strobe is high; the other strobe is always 0.
  - dmx_data and dmx_sel must not change.
  - The ack of the non-selected channel is ignored.
  - On an edge with the selected ack high: drop the strobe, increment sent_cnt[dmx_sel] (saturating at all-ones), and go to IDLE. in_ready is high in the next cycle.
  - Otherwise the timeout counter increments.
  - Timeout fires when TIMEOUT_CYC≠0 and the strobe has been high for TIMEOUT_CYC edges without ack. At that edge: drop the strobe, set timeout_err=1 for exactly one cycle, increment drop_cnt (saturating), and go to IDLE.
  - If ack and timeout coincide on the same edge, ack wins: the word counts as delivered and there is no error.
- Throughput:
  - There is no pipelining; one word is in flight at a time.
  - Minimum period per word is SETUP_CYC+2 cycles (handshake, setup, one strobe cycle with immediate ack, back to IDLE).
- in_valid while the block is busy is not accepted. The source must hold the word until in_ready.
- The counters are never cleared except by reset.

Test Plan:
- Reset, then in_valid=1, in_data=32'hDEADBEEF, in_dest=0, SETUP_CYC=2; ch0_ack pulses on the first strobe cycle. Required: dmx_data=DEADBEEF and dmx_sel=0 after E0; ch0_stb high at E0+2 for one cycle; ch1_stb stays 0; sent_cnt0=1; in_ready back to 1.
- Send 32'h12345678 to dest=1, with ch0_ack held at 1 and ch1_ack delayed 5 cycles. Required: ch1_stb high for exactly 5 cycles; ch0_ack has no effect; sent_cnt1=1, sent_cnt0 unchanged.
- TIMEOUT_CYC=4, dest=0, no ack. Required: ch0_stb high for 4 cycles, then low; timeout_err pulses for 1 cycle; drop_cnt=1; in_ready=1 on the next cycle.
- TIMEOUT_CYC=4 with ch0_ack asserted on the 4th strobe edge. Required: delivered, sent_cnt0 increments, timeout_err=0, drop_cnt unchanged.
- Assert rst_n=0 for one edge mid-STROBE (dest=1). Required: next cycle ch1_stb=0, dmx_sel=0, dmx_data=0, all counters 0, in_ready=1. A following word is then delivered normally.
- CNT_W=4: deliver 17 words to channel 0 back-to-back with immediate ack. Required: sent_cnt0 saturates at 15; back-to-back spacing is SETUP_CYC+2 cycles.
